// File: rtl/conv_frame_loader.sv
// Serial-to-parallel loader for the strided convolution stage: assembles one
// filter and one input frame from a valid/ready word stream and holds them until consumed.
module conv_frame_loader #(
  parameter int input_size  = 7,
  parameter int filter_size = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [31:0]                            in_data,
  input  logic                                   keep_filter,
  output logic [input_size*input_size*32-1:0]    input_data,
  output logic [filter_size*filter_size*32-1:0]  filter,
  output logic                                   frame_valid,
  input  logic                                   frame_ready,
  output logic                                   filter_loaded
);

  localparam int IN_WORDS  = input_size * input_size;
  localparam int FLT_WORDS = filter_size * filter_size;
  localparam int MAX_WORDS = (IN_WORDS > FLT_WORDS) ? IN_WORDS : FLT_WORDS;
  localparam int CW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {
    LOAD_FILTER,
    LOAD_INPUT,
    PRESENT
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [IN_WORDS*32-1:0]        input_q, input_d;
  logic [FLT_WORDS*32-1:0]       filter_q, filter_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          filter_loaded_q, filter_loaded_d;
  logic                          xfer;

  // in_ready is a pure decode of the registered state so it never combinationally follows in_valid
  assign in_ready = (state_q != PRESENT);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    input_d         = input_q;
    filter_d        = filter_q;
    frame_valid_d   = frame_valid_q;
    filter_loaded_d = filter_loaded_q;
    case (state_q)
      LOAD_FILTER: begin
        if (xfer) begin
          filter_d[cnt_q*32 +: 32] = in_data;
          if (cnt_q == CW'(FLT_WORDS - 1)) begin
            cnt_d           = '0;
            filter_loaded_d = 1'b1;
            state_d         = LOAD_INPUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_INPUT: begin
        if (xfer) begin
          input_d[cnt_q*32 +: 32] = in_data;
          if (cnt_q == CW'(IN_WORDS - 1)) begin
            cnt_d         = '0;
            frame_valid_d = 1'b1;
            state_d       = PRESENT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        // Old frame words stay in place; the next load overwrites them one by one
        if (frame_valid_q && frame_ready) begin
          frame_valid_d = 1'b0;
          if (keep_filter) begin
            state_d = LOAD_INPUT;
          end else begin
            state_d         = LOAD_FILTER;
            filter_loaded_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = LOAD_FILTER;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LOAD_FILTER;
      cnt_q           <= '0;
      input_q         <= '0;
      filter_q        <= '0;
      frame_valid_q   <= 1'b0;
      filter_loaded_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      input_q         <= input_d;
      filter_q        <= filter_d;
      frame_valid_q   <= frame_valid_d;
      filter_loaded_q <= filter_loaded_d;
    end
  end

  assign input_data    = input_q;
  assign filter        = filter_q;
  assign frame_valid   = frame_valid_q;
  assign filter_loaded = filter_loaded_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed self-checking bench for conv_frame_loader: default 7x7/3x3 instance
// plus a 5x5/5x5 instance for the equal-size parameter case.
module tb_conv_frame_loader;

  logic clk;
  logic rst_n;

  logic         in_valid, in_ready, keep_filter, frame_valid, frame_ready, filter_loaded;
  logic [31:0]  in_data;
  logic [49*32-1:0] input_data;
  logic [9*32-1:0]  filter;

  logic         b_in_valid, b_in_ready, b_keep_filter, b_frame_valid, b_frame_ready, b_filter_loaded;
  logic [31:0]  b_in_data;
  logic [25*32-1:0] b_input_data;
  logic [25*32-1:0] b_filter;

  int checks;
  int errors;

  conv_frame_loader #(.input_size(7), .filter_size(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .keep_filter(keep_filter),
    .input_data(input_data), .filter(filter),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .filter_loaded(filter_loaded)
  );

  conv_frame_loader #(.input_size(5), .filter_size(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .keep_filter(b_keep_filter),
    .input_data(b_input_data), .filter(b_filter),
    .frame_valid(b_frame_valid), .frame_ready(b_frame_ready),
    .filter_loaded(b_filter_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          reps;
    logic        v;
    logic [31:0] base;
    logic        fr;
    logic        kf;
    logic        exp_ir;
    logic        exp_fv;
    logic        exp_fl;
    int          chk;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] words [49];

  function automatic logic [31:0] inWord(input int k);
    return input_data[k*32 +: 32];
  endfunction

  function automatic logic [31:0] fltWord(input int k);
    return filter[k*32 +: 32];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic fr, input logic kf);
    in_valid    = v;
    in_data     = d;
    frame_ready = fr;
    keep_filter = kf;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusB(input logic v, input logic [31:0] d, input logic fr, input logic kf);
    b_in_valid    = v;
    b_in_data     = d;
    b_frame_ready = fr;
    b_keep_filter = kf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int cycles;
    logic v;

    checks = 0;
    errors = 0;

    // Control sequence starting from a presented frame holding filter {1..9}
    tbl[0] = '{1,  1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[1] = '{1,  1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    tbl[2] = '{48, 1'b1, 32'd200,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[3] = '{1,  1'b1, 32'd248,      1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[4] = '{1,  1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{8,  1'b1, 32'hA0,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{1,  1'b1, 32'hA8,       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; frame_ready = 1'b0; keep_filter = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_frame_ready = 1'b0; b_keep_filter = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("reset filter_loaded", {31'd0, filter_loaded}, 32'd0);
    checkOutput("reset input_data[0]", inWord(0), 32'd0);
    checkOutput("reset input_data[48]", inWord(48), 32'd0);
    checkOutput("reset filter[0]", fltWord(0), 32'd0);
    checkOutput("reset filter[8]", fltWord(8), 32'd0);
    #2 rst_n = 1'b1;
    #1 checkOutput("in_ready after reset", {31'd0, in_ready}, 32'd1);

    // First frame: filter 1..9, input 100..148, in_valid held high
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      checkOutput($sformatf("filter_loaded after word %0d", i), {31'd0, filter_loaded}, {31'd0, (i == 9)});
    end
    for (int k = 0; k < 9; k++) checkOutput($sformatf("filter[%0d]", k), fltWord(k), 32'(k + 1));
    for (int i = 0; i < 49; i++) begin
      applyStimulus(1'b1, 32'(100 + i), 1'b0, 1'b0);
      checkOutput($sformatf("frame_valid after input %0d", i), {31'd0, frame_valid}, {31'd0, (i == 48)});
    end
    checkOutput("input_data[0]", inWord(0), 32'd100);
    checkOutput("input_data[48]", inWord(48), 32'd148);
    checkOutput("in_ready while presenting", {31'd0, in_ready}, 32'd0);

    // Stalled present: in_valid with junk must be ignored
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      checkOutput("stall frame_valid", {31'd0, frame_valid}, 32'd1);
      checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall input_data[0]", inWord(0), 32'd100);
      checkOutput("stall input_data[48]", inWord(48), 32'd148);
      checkOutput("stall filter[0]", fltWord(0), 32'd1);
    end

    // Table: keep_filter handshake, reload, then handshake without keep and new filter
    for (int r = 0; r < 7; r++) begin
      for (int j = 0; j < tbl[r].reps; j++)
        applyStimulus(tbl[r].v, tbl[r].base + 32'(j), tbl[r].fr, tbl[r].kf);
      checkOutput($sformatf("row%0d in_ready", r), {31'd0, in_ready}, {31'd0, tbl[r].exp_ir});
      checkOutput($sformatf("row%0d frame_valid", r), {31'd0, frame_valid}, {31'd0, tbl[r].exp_fv});
      checkOutput($sformatf("row%0d filter_loaded", r), {31'd0, filter_loaded}, {31'd0, tbl[r].exp_fl});
      if (tbl[r].chk == 1) begin
        for (int k = 0; k < 49; k++) checkOutput($sformatf("kept input_data[%0d]", k), inWord(k), 32'(200 + k));
        for (int k = 0; k < 9; k++) checkOutput($sformatf("kept filter[%0d]", k), fltWord(k), 32'(k + 1));
      end else if (tbl[r].chk == 2) begin
        for (int k = 0; k < 9; k++) checkOutput($sformatf("new filter[%0d]", k), fltWord(k), 32'hA0 + 32'(k));
      end
    end

    // Input load with random in_valid gaps
    acc = 0;
    cycles = 0;
    while (acc < 49 && cycles < 1000) begin
      v = 1'($urandom_range(0, 1));
      if (v) words[acc] = $urandom;
      applyStimulus(v, v ? words[acc] : 32'h0, 1'b0, 1'b0);
      if (v) acc++;
      cycles++;
      checkOutput($sformatf("gap frame_valid acc=%0d", acc), {31'd0, frame_valid}, {31'd0, (acc == 49)});
    end
    checkOutput("gap load completed", 32'(acc), 32'd49);
    for (int k = 0; k < 49; k++) checkOutput($sformatf("gap input_data[%0d]", k), inWord(k), words[k]);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("gap frame_valid held", {31'd0, frame_valid}, 32'd1);

    // Asynchronous reset in the middle of an input load
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("keep handshake frame_valid", {31'd0, frame_valid}, 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'(300 + i), 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async rst frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("async rst filter_loaded", {31'd0, filter_loaded}, 32'd0);
    checkOutput("async rst in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("async rst input_data[0]", inWord(0), 32'd0);
    checkOutput("async rst input_data[19]", inWord(19), 32'd0);
    checkOutput("async rst filter[0]", fltWord(0), 32'd0);
    checkOutput("async rst filter[8]", fltWord(8), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'(400 + i), 1'b0, 1'b0);
    checkOutput("reload filter_loaded", {31'd0, filter_loaded}, 32'd1);
    for (int i = 0; i < 49; i++) begin
      applyStimulus(1'b1, 32'(500 + i), 1'b0, 1'b0);
      if (i >= 47)
        checkOutput($sformatf("reload frame_valid %0d", i), {31'd0, frame_valid}, {31'd0, (i == 48)});
    end
    for (int k = 0; k < 9; k++) checkOutput($sformatf("reload filter[%0d]", k), fltWord(k), 32'(400 + k));
    checkOutput("reload input_data[0]", inWord(0), 32'd500);
    checkOutput("reload input_data[20]", inWord(20), 32'd520);
    checkOutput("reload input_data[48]", inWord(48), 32'd548);
    in_valid = 1'b0;

    // Equal filter and frame size instance
    for (int i = 0; i < 25; i++) begin
      applyStimulusB(1'b1, 32'(700 + i), 1'b0, 1'b0);
      checkOutput($sformatf("B filter_loaded %0d", i), {31'd0, b_filter_loaded}, {31'd0, (i == 24)});
    end
    for (int i = 0; i < 25; i++) begin
      applyStimulusB(1'b1, 32'(800 + i), 1'b0, 1'b0);
      checkOutput($sformatf("B frame_valid %0d", i), {31'd0, b_frame_valid}, {31'd0, (i == 24)});
    end
    checkOutput("B input_data[0]", b_input_data[0 +: 32], 32'd800);
    checkOutput("B input_data[24]", b_input_data[24*32 +: 32], 32'd824);
    checkOutput("B filter[0]", b_filter[0 +: 32], 32'd700);
    checkOutput("B filter[24]", b_filter[24*32 +: 32], 32'd724);
    applyStimulusB(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("B handshake frame_valid", {31'd0, b_frame_valid}, 32'd0);
    checkOutput("B handshake filter_loaded", {31'd0, b_filter_loaded}, 32'd0);
    applyStimulusB(1'b1, 32'd900, 1'b0, 1'b0);
    checkOutput("B counter restart filter[0]", b_filter[0 +: 32], 32'd900);
    checkOutput("B counter restart filter[1]", b_filter[32 +: 32], 32'd701);
    b_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
